// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port (core / debug) arbiter in front of a single-port 64-bit data
//   memory. Grants are combinational from the requests and a round-robin
//   last-granted pointer. A granted access drives the memory in the same
//   cycle. Its response (done, plus rdata for loads) appears exactly one
//   cycle later. A new grant can be issued in the same cycle a response is
//   delivered, so the arbiter sustains one access per cycle.
//
// Optional feature (macro DMEM_ARB_ALIGN_CHECK_EN):
//   When defined, an address with addr[2:0] != 0 is misaligned. Such an
//   access is still granted and completed, but it never reaches the memory.
//   The port's err bit is set with done, and rdata is 0.
//   When undefined, addr[2:0] is ignored and err is tied to 2'b00.
//
// Ports
//   clk, rst                   clock, async active-high reset
//   core_req/we/addr/wdata     core request (held until granted)
//   core_gnt, core_done        accepted this cycle / completed this cycle
//   core_rdata                 load data, valid with core_done
//   dbg_*                      same set for the debug/loader port
//   err[1:0]                   misaligned flag per port ([0] core, [1] dbg)
//   mem_en/we/addr/wdata       memory strobe, write enable, word index, data
//   mem_rdata                  memory read data, one cycle after read strobe
//   conflict_cnt               saturating count of cycles with both req high
//
// State | meaning
// IDLE     | no response owed this cycle
// RSP_CORE | core access granted last cycle, core_done asserted now
// RSP_DBG  | debug access granted last cycle, dbg_done asserted now
module dmem_arbiter #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [63:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_done,
    output logic [63:0]       core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [63:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [63:0]       dbg_rdata,
    output logic [1:0]        err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RSP_CORE = 2'd1,
        RSP_DBG  = 2'd2
    } state_t;

    state_t state;
    logic   last_dbg;   // 1: debug was granted most recently
    logic   rsp_load;   // response being delivered belongs to a load
    logic   core_mis;
    logic   dbg_mis;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic rsp_err;
    assign core_mis = (core_addr[2:0] != 3'b000);
    assign dbg_mis  = (dbg_addr[2:0] != 3'b000);
`else
    logic unused_low_addr;
    assign core_mis        = 1'b0;
    assign dbg_mis         = 1'b0;
    assign unused_low_addr = ^{core_addr[2:0], dbg_addr[2:0]};
`endif

    // On a tie the port that did not win last time is served.
    // Reset masks the grants so nothing is accepted while rst is high.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!rst) begin
            core_gnt = core_req & (~dbg_req | last_dbg);
            dbg_gnt  = dbg_req & (~core_req | ~last_dbg);
        end
    end

    // Misaligned grants keep the memory bus idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt && !core_mis) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr[ADDR_W-1:3];
            mem_wdata = core_wdata;
        end else if (dbg_gnt && !dbg_mis) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr[ADDR_W-1:3];
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_dbg <= 1'b1;
            rsp_load <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            rsp_err  <= 1'b0;
`endif
        end else begin
            if (core_gnt) begin
                state    <= RSP_CORE;
                last_dbg <= 1'b0;
                rsp_load <= ~core_we;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                rsp_err  <= core_mis;
`endif
            end else if (dbg_gnt) begin
                state    <= RSP_DBG;
                last_dbg <= 1'b1;
                rsp_load <= ~dbg_we;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                rsp_err  <= dbg_mis;
`endif
            end else begin
                state    <= IDLE;
                rsp_load <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                rsp_err  <= 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (core_req && dbg_req && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign core_done = (state == RSP_CORE);
    assign dbg_done  = (state == RSP_DBG);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign core_rdata = (core_done && rsp_load && !rsp_err) ? mem_rdata : 64'd0;
    assign dbg_rdata  = (dbg_done && rsp_load && !rsp_err) ? mem_rdata : 64'd0;
    assign err        = {dbg_done & rsp_err, core_done & rsp_err};
`else
    assign core_rdata = (core_done && rsp_load) ? mem_rdata : 64'd0;
    assign dbg_rdata  = (dbg_done && rsp_load) ? mem_rdata : 64'd0;
    assign err        = 2'b00;
`endif

endmodule
